// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and defaults for uart_rx and uart_tx.
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;
    localparam int DEFAULT_CYCLES_PER_BIT = 104;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, resetting to 1.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling, one-cycle valid/ferr strobes.
import uart_pkg::*;

module uart_rx #(
    parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] out,
    output logic       valid,
    output logic       ferr,
    output logic       busy
);
    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CYCLES_PER_BIT / 2 - 1);

    uart_state_t   state;
    logic          rx_s;
    logic          rx_prev;
    logic [CW-1:0] cycles;
    logic [2:0]    index;
    logic [7:0]    shreg;

    sync_2ff u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rx_prev <= 1'b1;
            cycles  <= '0;
            index   <= '0;
            shreg   <= '0;
            out     <= '0;
            valid   <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            valid   <= 1'b0;
            ferr    <= 1'b0;
            rx_prev <= rx_s;
            case (state)
                IDLE: begin
                    cycles <= '0;
                    index  <= '0;
                    if (rx_prev && !rx_s) state <= START;
                end
                START: begin
                    if (cycles == MID) begin
                        cycles <= '0;
                        state  <= rx_s ? IDLE : DATA;
                    end else cycles <= cycles + 1'b1;
                end
                DATA: begin
                    if (cycles == LAST) begin
                        cycles <= '0;
                        shreg  <= {rx_s, shreg[7:1]};
                        index  <= index + 1'b1;
                        if (index == 3'd7) state <= STOP;
                    end else cycles <= cycles + 1'b1;
                end
                STOP: begin
                    if (cycles == LAST) begin
                        // leave mid-stop-bit so a following start edge is not missed
                        cycles <= '0;
                        state  <= IDLE;
                        if (rx_s) begin
                            out   <= shreg;
                            valid <= 1'b1;
                        end else ferr <= 1'b1;
                    end else cycles <= cycles + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at 8 and 104 cycles per bit.
module tb_uart_rx;
    localparam int N  = 8;
    localparam int H  = N / 2;
    localparam int N2 = 104;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic rx2 = 1'b1;
    logic [7:0] out, out2;
    logic valid, ferr, busy, valid2, ferr2, busy2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] vq[$];
    logic [7:0] v2q[$];
    int nferr = 0;
    int nferr2 = 0;
    int vcyc = -1;
    int brise = -1;
    int bfall = -1;
    logic prev_pulse = 1'b0;
    logic prev_busy = 1'b0;

    uart_rx #(.CYCLES_PER_BIT(N)) dut (
        .clk(clk), .rst(rst), .rx(rx), .out(out), .valid(valid), .ferr(ferr), .busy(busy)
    );
    uart_rx #(.CYCLES_PER_BIT(N2)) dut104 (
        .clk(clk), .rst(rst), .rx(rx2), .out(out2), .valid(valid2), .ferr(ferr2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vq.push_back(out);
            vcyc = cyc;
        end
        if (ferr) nferr++;
        if (valid || ferr || prev_pulse) begin
            checks++;
            if ((valid && ferr) || (prev_pulse && (valid || ferr))) begin
                errors++;
                $display("FAIL pulse_shape: valid=%b ferr=%b prev=%b, required single exclusive pulse", valid, ferr, prev_pulse);
            end
        end
        prev_pulse = valid | ferr;
        if (busy && !prev_busy) brise = cyc;
        if (!busy && prev_busy) bfall = cyc;
        prev_busy = busy;
        if (valid2) v2q.push_back(out2);
        if (ferr2) nferr2++;
    end

    task automatic clear_obs();
        vq.delete();
        nferr = 0;
        vcyc = -1;
        brise = -1;
        bfall = -1;
    endtask

    task automatic idle_bits(input int k);
        rx = 1'b1;
        repeat (k * N) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (N) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out !== 8'h00 || valid !== 1'b0 || ferr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h valid=%b ferr=%b busy=%b, required 00 0 0 0", out, valid, ferr, busy);
        end
        rst = 1'b0;
        idle_bits(2);
        checks++;
        if (busy !== 1'b0 || busy2 !== 1'b0 || out2 !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: busy=%b busy2=%b out2=%h, required 0 0 00", busy, busy2, out2);
        end
    endtask

    task automatic test_single();
        int c0;
        clear_obs();
        idle_bits(2);
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle_bits(2);
        checks++;
        if (vq.size() != 1 || vq[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_data: count=%0d first=%h, required 1 a5", vq.size(), vq.size() ? vq[0] : 8'hxx);
        end
        checks++;
        if (nferr != 0) begin
            errors++;
            $display("FAIL single_ferr: ferr pulses=%0d, required 0", nferr);
        end
        // 2 sync stages + edge register, then half a bit and nine full bits
        checks++;
        if (vcyc != c0 + 3 + H + 9 * N) begin
            errors++;
            $display("FAIL single_latency: valid at %0d, required %0d", vcyc, c0 + 3 + H + 9 * N);
        end
        checks++;
        if (brise != c0 + 3 || bfall != vcyc) begin
            errors++;
            $display("FAIL single_busy: rise=%0d fall=%0d, required %0d %0d", brise, bfall, c0 + 3, vcyc);
        end
        checks++;
        if (out !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: out=%h, required a5", out);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(2);
        checks++;
        if (vq.size() != 2 || vq[0] !== 8'h00 || vq[1] !== 8'hFF || nferr != 0) begin
            errors++;
            $display("FAIL back_to_back: count=%0d ferr=%0d, required 2 frames 00,ff and 0 ferr", vq.size(), nferr);
        end
    endtask

    task automatic test_glitch();
        int c0;
        clear_obs();
        c0 = cyc;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle_bits(3);
        checks++;
        if (vq.size() != 0 || nferr != 0) begin
            errors++;
            $display("FAIL glitch_pulse: valid=%0d ferr=%0d, required 0 0", vq.size(), nferr);
        end
        checks++;
        if (brise != c0 + 3 || bfall != c0 + 3 + H) begin
            errors++;
            $display("FAIL glitch_busy: rise=%0d fall=%0d, required %0d %0d", brise, bfall, c0 + 3, c0 + 3 + H);
        end
    endtask

    task automatic test_ferr();
        clear_obs();
        send_frame(8'h11, 1'b1);
        idle_bits(1);
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        checks++;
        if (vq.size() != 1 || vq[0] !== 8'h11 || nferr != 1) begin
            errors++;
            $display("FAIL frame_error: valid=%0d ferr=%0d, required 1 valid (11) and 1 ferr", vq.size(), nferr);
        end
        checks++;
        if (out !== 8'h11) begin
            errors++;
            $display("FAIL ferr_hold: out=%h, required 11", out);
        end
    endtask

    task automatic test_reset_abort();
        logic [9:0] f;
        clear_obs();
        f = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = f[i];
            repeat (N) @(negedge clk);
        end
        rx = f[5];
        repeat (N / 2) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || valid !== 1'b0 || ferr !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: out=%h busy=%b valid=%b ferr=%b, required 00 0 0 0", out, busy, valid, ferr);
        end
        rst = 1'b0;
        idle_bits(2);
        send_frame(8'h5A, 1'b1);
        idle_bits(2);
        checks++;
        if (vq.size() != 1 || vq[0] !== 8'h5A || nferr != 0) begin
            errors++;
            $display("FAIL abort_recover: valid=%0d ferr=%0d, required exactly one 5a", vq.size(), nferr);
        end
    endtask

    task automatic test_break();
        clear_obs();
        rx = 1'b0;
        repeat (30 * N) @(negedge clk);
        checks++;
        if (nferr != 1 || vq.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL break_ferr: ferr=%0d valid=%0d busy=%b, required 1 0 0", nferr, vq.size(), busy);
        end
        idle_bits(2);
        send_frame(8'h7E, 1'b1);
        idle_bits(2);
        checks++;
        if (vq.size() != 1 || vq[0] !== 8'h7E || nferr != 1) begin
            errors++;
            $display("FAIL break_recover: valid=%0d ferr=%0d, required one 7e and 1 ferr", vq.size(), nferr);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] last;
        logic [7:0] b;
        logic stop;
        int exp_ferr;
        int gap;
        clear_obs();
        last = 8'h7E;
        exp_ferr = 0;
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            // a low stop bit needs the line high again before the next start edge
            gap = stop ? $urandom_range(0, 2) : 1 + $urandom_range(0, 1);
            send_frame(b, stop);
            if (gap > 0) idle_bits(gap);
            if (stop) begin
                exp_q.push_back(b);
                last = b;
            end else exp_ferr++;
        end
        idle_bits(2);
        checks++;
        if (vq.size() != exp_q.size() || nferr != exp_ferr) begin
            errors++;
            $display("FAIL random_count: valid=%0d ferr=%0d, required %0d %0d", vq.size(), nferr, exp_q.size(), exp_ferr);
        end
        for (int i = 0; i < exp_q.size() && i < vq.size(); i++) begin
            checks++;
            if (vq[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_data[%0d]: got %h, required %h", i, vq[i], exp_q[i]);
            end
        end
        checks++;
        if (out !== last) begin
            errors++;
            $display("FAIL random_hold: out=%h, required %h", out, last);
        end
    endtask

    task automatic test_baud104();
        logic [9:0] f;
        logic [7:0] b;
        b = 8'($urandom);
        f = {1'b1, b, 1'b0};
        v2q.delete();
        nferr2 = 0;
        rx2 = 1'b1;
        repeat (N2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx2 = f[i];
            repeat (N2) @(negedge clk);
        end
        rx2 = 1'b1;
        repeat (2 * N2) @(negedge clk);
        checks++;
        if (v2q.size() != 1 || v2q[0] !== b || nferr2 != 0 || out2 !== b) begin
            errors++;
            $display("FAIL baud104: valid=%0d ferr=%0d out=%h, required one %h", v2q.size(), nferr2, out2, b);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_ferr();
        test_reset_abort();
        test_break();
        test_random();
        test_baud104();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
